// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the fifo write port between num_req producers.
// Grants one producer at a time for bursts of up to burst_len words and stalls on full.
module fifo_write_arbiter #(
  parameter int fifo_width = 8,
  parameter int num_req    = 4,
  parameter int burst_len  = 4
) (
  input  logic                          write_clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*fifo_width-1:0] req_data,
  output logic [num_req-1:0]            req_ready,
  input  logic                          full,
  output logic                          write_en,
  output logic [fifo_width-1:0]         write_data,
  output logic [$clog2(num_req)-1:0]    grant_id,
  output logic                          busy
);

  localparam int id_w  = $clog2(num_req);
  localparam int cnt_w = $clog2(burst_len) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [id_w-1:0]  last_id;
  logic [id_w-1:0]  sel_id;
  logic [id_w:0]    cand;
  logic [cnt_w-1:0] burst_cnt;
  logic             sel_found;
  logic             grant_valid;
  logic             active;
  logic             transfer;
  logic             last_beat;

  // Circular scan starting just above the last served requester, so it gets lowest priority.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= num_req; i++) begin
      cand = {1'b0, last_id} + (id_w+1)'(i);
      if (cand >= (id_w+1)'(num_req)) begin
        cand = cand - (id_w+1)'(num_req);
      end
      if (!sel_found && req_valid[cand[id_w-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[id_w-1:0];
      end
    end
  end

  assign active      = (state == GRANT) && !rst;
  assign grant_valid = req_valid[grant_id];
  assign transfer    = active && grant_valid && !full;
  assign last_beat   = (burst_cnt == cnt_w'(burst_len - 1));

  assign write_en   = transfer;
  assign write_data = transfer ? req_data[int'(grant_id)*fifo_width +: fifo_width] : '0;
  assign busy       = (state == GRANT);

  always_comb begin
    req_ready = '0;
    if (active && !full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // A stall on full holds both grant and counter; dropping valid forfeits the grant.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_id   <= id_w'(num_req - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_id  <= sel_id;
            last_id   <= sel_id;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!grant_valid) begin
            state <= IDLE;
          end else if (!full) begin
            burst_cnt <= burst_cnt + cnt_w'(1);
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of the project's `fifo` between `num_req` independent producers in the write-clock domain. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, drives `write_en`/`write_data` into the FIFO, and honours the FIFO `full` flag so that no word is lost or duplicated. It sits directly in front of `fifo` and runs entirely on the FIFO's `write_clk`.

## Interface
Parameters:
- `fifo_width`, 8: data width; must equal the connected FIFO's `fifo_width`.
- `num_req`, 4: number of requesters (2..16).
- `burst_len`, 4: maximum words per grant (>= 1).

Ports:
- `write_clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_valid`  in  num_req: bit i high means requester i has a word on its slice of `req_data`.
- `req_data`  in  num_req*fifo_width: requester i data occupies bits [i*fifo_width +: fifo_width].
- `req_ready`  out  num_req: one-hot or zero; bit i high means the word from requester i is accepted this cycle.
- `full`  in  1: FIFO full flag, already in the `write_clk` domain.
- `write_en`  out  1: FIFO write enable.
- `write_data`  out  fifo_width: FIFO write data.
- `grant_id`  out  clog2(num_req): index of the current grant holder; holds its last value when idle.
- `busy`  out  1: high while in GRANT.

## Operation
Registered state:
- FSM state: IDLE or GRANT.
- `grant_id`.
- Burst counter of width clog2(burst_len)+1.
- `last_id`: the most recently granted index.

IDLE:
- If any `req_valid` bit is set, select the first set bit scanning circularly from `last_id+1`, wrapping at `num_req`.
- Load `grant_id` and `last_id` with the selected index, clear the burst counter, and go to GRANT.
- If no bit is set, remain in IDLE.

GRANT, with g = `grant_id`:
- A transfer occurs when `req_valid[g] & ~full`.
- `req_ready[g]` = `~full` (combinational). All other `req_ready` bits are 0.
- `write_en` = `req_valid[g] & ~full`.
- `write_data` = slice g of `req_data` (combinational mux).
- On a transfer, the burst counter increments.
- Release occurs, and the FSM returns to IDLE, when either:
  - a transfer happens with counter == `burst_len-1`, or
  - `req_valid[g]` is 0 in any cycle.
- While `full` is high with `req_valid[g]` high: stall. Grant and counter hold, and there is no timeout.

Outputs in IDLE:
- `write_en`, `req_ready`, `busy` are 0.
- `write_data` is 0. It is gated to 0 whenever no transfer is occurring.

Reset (`rst` high at a clock edge):
- State becomes IDLE.
- `grant_id` becomes 0.
- `last_id` becomes `num_req-1`, so requester 0 has first priority.
- Counter becomes 0.
- While `rst` is high, `write_en` and `req_ready` are forced to 0 combinationally.
- A burst in progress when reset arrives is abandoned. Words already written stay in the FIFO, and no partial word is emitted.

Fairness: the requester just served has lowest priority at the next arbitration. With all requesters valid, the service order is 0,1,..,num_req-1,0,...

## Timing
- Arbitration latency: a request seen in IDLE at edge t gives `req_ready`/`write_en` in cycle t+1, provided `full` is low.
- Inter-grant gap: exactly one IDLE cycle between release and the next grant.
- Sustained throughput: `burst_len` words per `burst_len+1` cycles.
- Requester rule: `req_data` and `req_valid` must hold until `req_ready` is seen high. A requester may drop `req_valid` before acceptance; doing so forfeits the grant.
- `full` asserting in the same cycle a word is presented: no transfer that cycle. The word is written on the first cycle `full` is low.
- The FIFO `full` flag is registered within the FIFO. The arbiter adds no pipeline stage, so `write_en` is never asserted while `full` is high.

## Test plan
- Reset, then requester 2 alone sends 3 words A0..A2 with `burst_len`=4:
  - Grant appears 1 cycle after `req_valid`.
  - Writes happen on 3 consecutive cycles.
  - Valid drops, the arbiter returns to IDLE, `grant_id`=2.
- All 4 requesters continuously valid for 40 cycles:
  - Grant order is 0,1,2,3,0.
  - Each grant produces 4 writes followed by 1 idle cycle.
  - The FIFO receives the data in exactly that order.
- `full` forced high for 5 cycles mid-burst:
  - `write_en` is 0 during those 5 cycles.
  - The counter holds and no word is lost or duplicated.
  - The burst completes after `full` falls, totalling 4 words.
- Requester 1 drops valid after 2 of 4 words:
  - Release occurs.
  - The next grant goes to the next valid requester above 1, not back to 1.
- `rst` asserted during the third beat of a burst:
  - `write_en`/`req_ready` are 0 in that cycle.
  - After reset, requester 0 is granted first.
- End-to-end with the FIFO at depth 8 and a reader draining at ~71 MHz:
  - The read data sequence equals the concatenated grant order.
  - The bench checks `empty`/`full` flags.
